// File: rtl/inclusion_scanner.sv
// inclusion_scanner: captures one DW-bit word, walks a run-time loadable DEPTH-entry
// pattern/mask/result table one entry per cycle, and reports an OW-bit result with a
// level handshake on START/VALID.
// Optional build macro: INCLUSION_SCANNER_FIRST_MATCH_EN selects priority (first match)
// mode; when undefined every entry is scanned and the matching results are ORed.
module inclusion_scanner #(
    parameter int unsigned DW    = 8,
    parameter int unsigned OW    = 4,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          START,
    input  logic [DW-1:0] I,
    input  logic          CFG_WE,
    input  logic [AW-1:0] CFG_ADDR,
    input  logic [DW-1:0] CFG_PAT,
    input  logic [DW-1:0] CFG_MASK,
    input  logic [OW-1:0] CFG_RES,
    output logic [OW-1:0] O,
    output logic          HIT,
    output logic          VALID,
    output logic          BUSY
);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_e;

    state_e        r_state;
    state_e        w_state_nxt;

    logic [DW-1:0] r_pat  [DEPTH];
    logic [DW-1:0] r_mask [DEPTH];
    logic [OW-1:0] r_res  [DEPTH];

    logic [AW-1:0] r_mar;
    logic [DW-1:0] r_in;
    logic [OW-1:0] r_out;
    logic          r_hit_acc;
    logic [OW-1:0] r_o;
    logic          r_hit;

    logic          w_match;
    logic          w_last;
    logic          w_scan_end;
    logic [OW-1:0] w_out_nxt;
    logic          w_hit_nxt;
    logic [OW-1:0] w_o_fin;
    logic          w_hit_fin;
    logic          w_cfg_wr;

    // Evaluate the entry addressed by MAR and form the running/final results.
    always_comb begin
        w_match   = ((r_in & r_mask[r_mar]) == (r_pat[r_mar] & r_mask[r_mar]));
        w_last    = (r_mar == AW'(DEPTH - 1));
        w_out_nxt = r_out | (w_match ? r_res[r_mar] : '0);
        w_hit_nxt = r_hit_acc | w_match;
`ifdef INCLUSION_SCANNER_FIRST_MATCH_EN
        // Lowest matching index wins; a miss on the last entry reports nothing.
        w_scan_end = w_match | w_last;
        w_o_fin    = w_match ? r_res[r_mar] : '0;
        w_hit_fin  = w_match;
`else
        w_scan_end = w_last;
        w_o_fin    = w_out_nxt;
        w_hit_fin  = w_hit_nxt;
`endif
    end

    // Table writes are only honoured outside SCAN so a scan sees a stable table.
    assign w_cfg_wr = CFG_WE && (r_state != StScan);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic for the START/VALID level handshake.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (START) begin
                    w_state_nxt = StScan;
                end
            end
            StScan: begin
                if (w_scan_end) begin
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                // START must be seen low before another scan can be accepted.
                if (!START) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Rule table storage, cleared by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_pat[i]  <= '0;
                r_mask[i] <= '0;
                r_res[i]  <= '0;
            end
        end else if (w_cfg_wr) begin
            r_pat[CFG_ADDR]  <= CFG_PAT;
            r_mask[CFG_ADDR] <= CFG_MASK;
            r_res[CFG_ADDR]  <= CFG_RES;
        end
    end

    // Scan datapath: capture on accept, accumulate per entry, publish on DONE entry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mar     <= '0;
            r_in      <= '0;
            r_out     <= '0;
            r_hit_acc <= 1'b0;
            r_o       <= '0;
            r_hit     <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (START) begin
                        r_in      <= I;
                        r_mar     <= '0;
                        r_out     <= '0;
                        r_hit_acc <= 1'b0;
                    end
                end
                StScan: begin
                    r_mar     <= r_mar + AW'(1);
                    r_out     <= w_out_nxt;
                    r_hit_acc <= w_hit_nxt;
                    if (w_scan_end) begin
                        r_o   <= w_o_fin;
                        r_hit <= w_hit_fin;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs: O/HIT hold between DONE entries; VALID/BUSY decode the state.
    always_comb begin
        O     = r_o;
        HIT   = r_hit;
        VALID = (r_state == StDone);
        BUSY  = (r_state != StIdle);
    end

endmodule

// File: tb/tb_inclusion_scanner.sv
// Directed bench for inclusion_scanner; expected values are hand-computed for the
// table contents loaded below, with latencies chosen by the build mode.
module tb_inclusion_scanner;

    localparam int DEPTH = 8;
`ifdef INCLUSION_SCANNER_FIRST_MATCH_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic       clock;
    logic       reset_n;
    logic       START;
    logic [7:0] I;
    logic       CFG_WE;
    logic [2:0] CFG_ADDR;
    logic [7:0] CFG_PAT;
    logic [7:0] CFG_MASK;
    logic [3:0] CFG_RES;
    logic [3:0] O;
    logic       HIT;
    logic       VALID;
    logic       BUSY;

    int n_vec;
    int n_err;

    inclusion_scanner #(
        .DW    (8),
        .OW    (4),
        .DEPTH (DEPTH)
    ) u_dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .START    (START),
        .I        (I),
        .CFG_WE   (CFG_WE),
        .CFG_ADDR (CFG_ADDR),
        .CFG_PAT  (CFG_PAT),
        .CFG_MASK (CFG_MASK),
        .CFG_RES  (CFG_RES),
        .O        (O),
        .HIT      (HIT),
        .VALID    (VALID),
        .BUSY     (BUSY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [7:0] p, input logic [7:0] m,
                             input logic [3:0] r);
        CFG_WE   = 1'b1;
        CFG_ADDR = a;
        CFG_PAT  = p;
        CFG_MASK = m;
        CFG_RES  = r;
        tick();
        CFG_WE   = 1'b0;
    endtask

    // Raise START and pass the accept edge k.
    task automatic start_scan(input logic [7:0] din);
        START = 1'b1;
        I     = din;
        tick();
    endtask

    // Count edges until VALID, bounded.
    task automatic wait_valid(output int n);
        n = 0;
        while (!VALID && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic run_scan(input string tag, input logic [7:0] din, input int exp_lat,
                            input logic [3:0] exp_o, input logic exp_hit);
        int n;
        start_scan(din);
        wait_valid(n);
        check({tag, "_lat"}, 32'(n), 32'(exp_lat));
        check({tag, "_o"}, 32'(O), 32'(exp_o));
        check({tag, "_hit"}, 32'(HIT), 32'(exp_hit));
        START = 1'b0;
        tick();
        check({tag, "_valid_drop"}, 32'(VALID), 32'd0);
    endtask

    initial begin
        int n;
        n_vec    = 0;
        n_err    = 0;
        reset_n  = 1'b0;
        START    = 1'b0;
        I        = '0;
        CFG_WE   = 1'b0;
        CFG_ADDR = '0;
        CFG_PAT  = '0;
        CFG_MASK = '0;
        CFG_RES  = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_o", 32'(O), 32'd0);
        check("rst_hit", 32'(HIT), 32'd0);
        check("rst_valid", 32'(VALID), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        reset_n = 1'b1;
        tick();

        // Reset table: every mask is zero, so every entry matches with RES 0.
        start_scan(8'hA5);
        check("t1_busy", 32'(BUSY), 32'd1);
        check("t1_valid_early", 32'(VALID), 32'd0);
        wait_valid(n);
        check("t1_lat", 32'(n), PRIO ? 32'd1 : 32'(DEPTH));
        check("t1_o", 32'(O), 32'd0);
        check("t1_hit", 32'(HIT), 32'd1);
        repeat (3) tick();
        check("t1_hold_valid", 32'(VALID), 32'd1);
        check("t1_hold_busy", 32'(BUSY), 32'd1);
        START = 1'b0;
        tick();
        check("t1_idle_valid", 32'(VALID), 32'd0);
        check("t1_idle_busy", 32'(BUSY), 32'd0);

        // Load the rule table.
        for (int a = 0; a < DEPTH; a++) begin
            if (a == 2)      cfg_write(3'(a), 8'h0F, 8'h0F, 4'h2);
            else if (a == 5) cfg_write(3'(a), 8'hF0, 8'hF0, 4'h8);
            else             cfg_write(3'(a), 8'h00, 8'hFF, 4'h1);
        end
        run_scan("ff", 8'hFF, PRIO ? 3 : DEPTH, PRIO ? 4'h2 : 4'hA, 1'b1);
        run_scan("zero", 8'h00, PRIO ? 1 : DEPTH, 4'h1, 1'b1);

        // Write to entry 5 during SCAN must be dropped.
        start_scan(8'hF0);
        check("mid_o_held", 32'(O), 32'h1);
        tick();
        CFG_WE   = 1'b1;
        CFG_ADDR = 3'd5;
        CFG_PAT  = 8'hF0;
        CFG_MASK = 8'hF0;
        CFG_RES  = 4'h4;
        tick();
        CFG_WE   = 1'b0;
        wait_valid(n);
        check("mid_lat", 32'(n + 2), PRIO ? 32'd6 : 32'(DEPTH));
        check("mid_o", 32'(O), 32'h8);
        START = 1'b0;
        tick();
        run_scan("mid_next", 8'hF0, PRIO ? 6 : DEPTH, 4'h8, 1'b1);

        // Same write in IDLE takes effect.
        cfg_write(3'd5, 8'hF0, 8'hF0, 4'h4);
        run_scan("idle_wr", 8'hF0, PRIO ? 6 : DEPTH, 4'h4, 1'b1);
        run_scan("nomatch", 8'h33, DEPTH, 4'h0, 1'b0);

        // Write and accept on the same IDLE edge: the scan sees the new entry 0.
        START    = 1'b1;
        I        = 8'hF0;
        CFG_WE   = 1'b1;
        CFG_ADDR = 3'd0;
        CFG_PAT  = 8'hF0;
        CFG_MASK = 8'hFF;
        CFG_RES  = 4'h1;
        tick();
        CFG_WE   = 1'b0;
        wait_valid(n);
        check("same_lat", 32'(n), PRIO ? 32'd1 : 32'(DEPTH));
        check("same_o", 32'(O), PRIO ? 32'h1 : 32'h5);
        START = 1'b0;
        tick();

        // Asynchronous reset in the middle of a scan, at MAR=3.
        start_scan(8'h33);
        repeat (3) tick();
        check("mr_busy", 32'(BUSY), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("mr_o", 32'(O), 32'd0);
        check("mr_hit", 32'(HIT), 32'd0);
        check("mr_valid", 32'(VALID), 32'd0);
        check("mr_busy_clr", 32'(BUSY), 32'd0);
        START = 1'b0;
        #1 reset_n = 1'b1;
        tick();
        // Cleared table: every entry matches again.
        run_scan("cleared", 8'hA5, PRIO ? 1 : DEPTH, 4'h0, 1'b1);

        // Held START across DONE, then a one-cycle gap resamples I.
        cfg_write(3'd0, 8'h11, 8'hFF, 4'h6);
        start_scan(8'h11);
        wait_valid(n);
        check("hs_lat", 32'(n), PRIO ? 32'd1 : 32'(DEPTH));
        check("hs_o", 32'(O), 32'h6);
        I = 8'h22;
        repeat (3) tick();
        check("hs_hold_valid", 32'(VALID), 32'd1);
        check("hs_hold_busy", 32'(BUSY), 32'd1);
        check("hs_hold_o", 32'(O), 32'h6);
        START = 1'b0;
        tick();
        check("hs_idle", 32'(BUSY), 32'd0);
        run_scan("hs_resample", 8'h22, PRIO ? 2 : DEPTH, 4'h0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
